// File: rtl/mem_master.sv
// Burst master for a 16x8 synchronous memory: streams write bursts in and read bursts out.
// Optional MEM_MASTER_BUSY_ERR_EN adds an err pulse for a start that arrives while busy.
module mem_master (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       op,
   input  logic [3:0] base_ad,
   input  logic [3:0] len,
   input  logic [7:0] wdata,
   input  logic       wvalid,
   output logic       wready,
   output logic [7:0] rdata,
   output logic       rvalid,
   output logic       busy,
   output logic       done,
   output logic       mem_wr,
   output logic       mem_rd,
   output logic [3:0] mem_ad,
   output logic [7:0] mem_din,
   input  logic [7:0] mem_dout
`ifdef MEM_MASTER_BUSY_ERR_EN
   ,
   output logic       err
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      FLUSH,
      READ,
      DRAIN,
      DONE
   } state_t;

   state_t     state;
   logic [3:0] cur_ad;
   logic [3:0] cnt;
   logic       rd_p1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cur_ad  <= 4'd0;
         cnt     <= 4'd0;
         rd_p1   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         wready  <= 1'b0;
         rvalid  <= 1'b0;
         rdata   <= 8'd0;
         mem_wr  <= 1'b0;
         mem_rd  <= 1'b0;
         mem_ad  <= 4'd0;
         mem_din <= 8'd0;
      end else begin
         // p1: mem_dout is valid in the cycle after each mem_rd cycle; register it here
         rd_p1  <= mem_rd;
         rvalid <= rd_p1;
         if (rd_p1)
            rdata <= mem_dout;

         case (state)
            IDLE: begin
               mem_wr <= 1'b0;
               mem_rd <= 1'b0;
               done   <= 1'b0;
               if (start) begin
                  cnt  <= len;
                  busy <= 1'b1;
                  if (op) begin
                     state  <= READ;
                     mem_rd <= 1'b1;
                     mem_ad <= base_ad;
                     cur_ad <= base_ad + 4'd1;
                  end else begin
                     state  <= WRITE;
                     wready <= 1'b1;
                     cur_ad <= base_ad;
                  end
               end
            end
            WRITE: begin
               if (wvalid) begin
                  mem_wr  <= 1'b1;
                  mem_ad  <= cur_ad;
                  mem_din <= wdata;
                  cur_ad  <= cur_ad + 4'd1;
                  cnt     <= cnt - 4'd1;
                  if (cnt == 4'd0) begin
                     state  <= FLUSH;
                     wready <= 1'b0;
                  end
               end else begin
                  mem_wr <= 1'b0;
               end
            end
            FLUSH: begin
               mem_wr <= 1'b0;
               done   <= 1'b1;
               state  <= DONE;
            end
            READ: begin
               if (cnt == 4'd0) begin
                  mem_rd <= 1'b0;
                  state  <= DRAIN;
               end else begin
                  mem_ad <= cur_ad;
                  cur_ad <= cur_ad + 4'd1;
                  cnt    <= cnt - 4'd1;
               end
            end
            DRAIN: begin
               // once the last returning word has moved into rdata, rvalid is high now
               if (!rd_p1) begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state  <= IDLE;
               busy   <= 1'b0;
               done   <= 1'b0;
               wready <= 1'b0;
               mem_wr <= 1'b0;
               mem_rd <= 1'b0;
            end
         endcase
      end
   end

`ifdef MEM_MASTER_BUSY_ERR_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         err <= 1'b0;
      else
         err <= start && busy;
   end
`endif

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with a behavioural 16x8 memory and an event log.
// Build with MEM_MASTER_BUSY_ERR_EN to also exercise the err output.
module tb_mem_master;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       op = 1'b0;
   logic [3:0] base_ad = 4'd0;
   logic [3:0] len = 4'd0;
   logic [7:0] wdata = 8'd0;
   logic       wvalid = 1'b0;
   logic       wready, rvalid, busy, done, mem_wr, mem_rd;
   logic [7:0] rdata, mem_din, mem_dout;
   logic [3:0] mem_ad;
`ifdef MEM_MASTER_BUSY_ERR_EN
   logic       err;
`else
   logic       err = 1'b0;
`endif

   mem_master dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .base_ad(base_ad), .len(len),
      .wdata(wdata), .wvalid(wvalid), .wready(wready), .rdata(rdata), .rvalid(rvalid),
      .busy(busy), .done(done), .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_ad(mem_ad),
      .mem_din(mem_din), .mem_dout(mem_dout)
`ifdef MEM_MASTER_BUSY_ERR_EN
      , .err(err)
`endif
   );

   always #5 clk = ~clk;

   logic [7:0] mem [16];
   always @(posedge clk) begin
      if (mem_wr) mem[mem_ad] <= mem_din;
      mem_dout <= mem_rd ? mem[mem_ad] : 8'hxx;
   end

   int cyc = 0;
   int wr_ad[$], wr_d[$], wr_c[$], rd_ad[$], rd_c[$], rv_d[$], rv_c[$], dn_c[$];
   int both_hi = 0;
   int err_n = 0;
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (mem_wr) begin wr_ad.push_back(int'(mem_ad)); wr_d.push_back(int'(mem_din)); wr_c.push_back(cyc); end
      if (mem_rd) begin rd_ad.push_back(int'(mem_ad)); rd_c.push_back(cyc); end
      if (rvalid) begin rv_d.push_back(int'(rdata)); rv_c.push_back(cyc); end
      if (done) dn_c.push_back(cyc);
      if (mem_wr && mem_rd) both_hi = both_hi + 1;
      if (err) err_n = err_n + 1;
   end

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] dbuf [16];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      assert (obs === exp) else begin
         n_errors = n_errors + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int qget(input int q[$], input int i);
      return (i >= 0 && i < q.size()) ? q[i] : -1;
   endfunction

   task automatic clear_log();
      wr_ad.delete(); wr_d.delete(); wr_c.delete(); rd_ad.delete(); rd_c.delete();
      rv_d.delete(); rv_c.delete(); dn_c.delete(); err_n = 0;
   endtask

   task automatic start_burst(input logic o, input logic [3:0] b, input logic [3:0] l);
      start = 1'b1; op = o; base_ad = b; len = l;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic write_beats(input int n, input int stall);
      for (int i = 0; i < n; i++) begin
         wvalid = 1'b1; wdata = dbuf[i];
         @(negedge clk);
         if (stall > 0 && i < n - 1) begin
            wvalid = 1'b0;
            repeat (stall) @(negedge clk);
         end
      end
      wvalid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input bit poke);
      int k = 0;
      while (done !== 1'b1 && k < 80) begin @(negedge clk); k++; end
      chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
      if (poke) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_idle_wready"}, {31'd0, wready}, 32'd0);
   endtask

   task automatic check_wr(input string tag, input int b, input int n, input int gap);
      chk({tag, "_nwr"}, wr_c.size(), n);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_wr_ad"}, qget(wr_ad, i), (b + i) % 16);
         chk({tag, "_wr_d"}, qget(wr_d, i), int'(dbuf[i]));
         if (i > 0) chk({tag, "_wr_gap"}, qget(wr_c, i) - qget(wr_c, i - 1), gap);
      end
      chk({tag, "_ndone"}, dn_c.size(), 1);
      chk({tag, "_done_lat"}, qget(dn_c, 0) - qget(wr_c, n - 1), 1);
   endtask

   task automatic check_rd(input string tag, input int b, input int n);
      chk({tag, "_nrd"}, rd_c.size(), n);
      chk({tag, "_nrv"}, rv_c.size(), n);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_rd_ad"}, qget(rd_ad, i), (b + i) % 16);
         chk({tag, "_rv_d"}, qget(rv_d, i), int'(dbuf[i]));
         chk({tag, "_rv_lat"}, qget(rv_c, i) - qget(rd_c, i), 2);
         if (i > 0) chk({tag, "_rd_gap"}, qget(rd_c, i) - qget(rd_c, i - 1), 1);
      end
      chk({tag, "_ndone"}, dn_c.size(), 1);
      chk({tag, "_done_lat"}, qget(dn_c, 0) - qget(rv_c, n - 1), 1);
      chk({tag, "_nwr"}, wr_c.size(), 0);
   endtask

   logic [31:0] outs;
   always_comb outs = {8'd0, busy, done, wready, rvalid, mem_wr, mem_rd, err, 1'b0,
                       4'd0, mem_ad, mem_din};

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'd0;
      // reset state
      #1;
      chk("reset_outs", outs, 32'd0);
      chk("reset_rdata", {24'd0, rdata}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // start on the first edge after reset, then abort a read mid-burst
      start_burst(1'b1, 4'd0, 4'd7);
      chk("start_after_reset_busy", {31'd0, busy}, 32'd1);
      chk("read_wready_low", {31'd0, wready}, 32'd0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_outs", outs, 32'd0);
      chk("abort_rdata", {24'd0, rdata}, 32'd0);
      clear_log();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (12) @(negedge clk);
      chk("abort_ndone", dn_c.size(), 0);
      chk("abort_nrv", rv_c.size(), 0);
      chk("abort_nrd", rd_c.size(), 0);
      chk("abort_busy", {31'd0, busy}, 32'd0);

      // write then read back base 2, four words
      dbuf[0] = 8'h11; dbuf[1] = 8'h22; dbuf[2] = 8'h33; dbuf[3] = 8'h44;
      clear_log();
      start_burst(1'b0, 4'd2, 4'd3);
      chk("wr_wready_high", {31'd0, wready}, 32'd1);
      chk("wr_busy_high", {31'd0, busy}, 32'd1);
      write_beats(4, 0);
      wait_done("wr2", 1'b0);
      check_wr("wr2", 2, 4, 1);
      clear_log();
      start_burst(1'b1, 4'd2, 4'd3);
      wait_done("rd2", 1'b0);
      check_rd("rd2", 2, 4);

      // write with a three-cycle stall between two beats
      dbuf[0] = 8'hA5; dbuf[1] = 8'h5A;
      clear_log();
      start_burst(1'b0, 4'd8, 4'd1);
      write_beats(2, 3);
      wait_done("stall", 1'b0);
      check_wr("stall", 8, 2, 4);

      // full 16-word burst, written then read back
      for (int i = 0; i < 16; i++) dbuf[i] = 8'(i);
      clear_log();
      start_burst(1'b0, 4'd0, 4'd15);
      write_beats(16, 0);
      wait_done("wrfull", 1'b0);
      check_wr("wrfull", 0, 16, 1);
      clear_log();
      start_burst(1'b1, 4'd0, 4'd15);
      wait_done("rdfull", 1'b0);
      check_rd("rdfull", 0, 16);

      // address wrap 14,15,0,1
      dbuf[0] = 8'h0E; dbuf[1] = 8'h0F; dbuf[2] = 8'h00; dbuf[3] = 8'h01;
      clear_log();
      start_burst(1'b1, 4'd14, 4'd3);
      wait_done("wrap", 1'b0);
      check_rd("wrap", 14, 4);

      // start during READ and during DONE is ignored
      dbuf[0] = 8'h04; dbuf[1] = 8'h05; dbuf[2] = 8'h06; dbuf[3] = 8'h07;
      clear_log();
      start_burst(1'b1, 4'd4, 4'd3);
      start = 1'b1; op = 1'b0;
      @(negedge clk);
      start = 1'b0;
      wait_done("ign", 1'b1);
      repeat (5) @(negedge clk);
      chk("ign_busy_stays_low", {31'd0, busy}, 32'd0);
      check_rd("ign", 4, 4);
`ifdef MEM_MASTER_BUSY_ERR_EN
      chk("ign_err_pulses", err_n, 2);
`endif

      chk("never_both_strobes", both_hi, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 SHALL have parameter set: none; depth fixed at 16 words x 8 bits, address 4 bits.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  request; sampled only in IDLE.
REQ-005 op  in  1  0 = write burst, 1 = read burst; sampled with start.
REQ-006 base_ad  in  4  first word address; sampled with start.
REQ-007 len  in  4  burst length minus one (0..15 gives 1..16 words); sampled with start.
REQ-008 wdata  in  8  write-stream data.
REQ-009 wvalid  in  1  wdata valid.
REQ-010 wready  out  1  write beat accepted when wvalid and wready are both high on a rising edge.
REQ-011 rdata  out  8  read-stream data, registered.
REQ-012 rvalid  out  1  rdata valid for one cycle per word; no backpressure.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse at burst completion.
REQ-015 mem_wr, mem_rd  out  1 each  registered strobes to memory; never both high.
REQ-016 mem_ad  out  4  registered memory address.
REQ-017 mem_din  out  8  registered write data to memory.
REQ-018 mem_dout  in  8  memory read data, valid the cycle after a cycle with mem_rd high; otherwise may be Z/X and SHALL be ignored.

Function
REQ-019 States SHALL be IDLE, WRITE, FLUSH, READ, DRAIN, DONE.
REQ-020 IDLE: start=1 latches op/base_ad/len, loads word counter = len and cur_ad = base_ad; op=0 -> WRITE, op=1 -> READ.
REQ-021 WRITE: wready=1; each accepted beat registers mem_wr=1, mem_ad=cur_ad, mem_din=wdata for the next cycle; cur_ad increments; counter decrements.
REQ-022 WRITE with wvalid=0: mem_wr=0 next cycle; cur_ad and counter hold; no timeout.
REQ-023 Final beat accepted (counter=0) -> FLUSH (last mem_wr visible, wready=0) -> DONE.
REQ-024 READ: entered with mem_rd=1, mem_ad=base_ad; one read issued per cycle for len+1 consecutive cycles, cur_ad incrementing; then mem_rd=0 -> DRAIN.
REQ-025 rdata SHALL register mem_dout the cycle after each mem_rd cycle; rvalid SHALL be high 2 cycles after the matching mem_rd cycle; words delivered in address order.
REQ-026 DRAIN SHALL hold until the last rvalid has been driven, then go to DONE.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE; done SHALL follow the last mem_wr (write) or last rvalid (read) by exactly one cycle.
REQ-028 Address SHALL wrap modulo 16 (15 -> 0) with no error.
REQ-029 start outside IDLE (including DONE) SHALL be ignored; no queuing.
REQ-030 wready SHALL be 0 outside WRITE; mem_wr/mem_rd SHALL be 0 outside WRITE/FLUSH/READ/DRAIN issue cycles.

Reset
REQ-031 rst low SHALL immediately force state IDLE and busy, done, wready, rvalid, mem_wr, mem_rd = 0, mem_ad = 0, mem_din = 0, rdata = 0.
REQ-032 Reset mid-burst SHALL abort: no further memory strobes, no done, no rvalid for outstanding reads.
REQ-033 After rst returns high, first start SHALL be accepted on the first rising edge.

Configuration
REQ-034 Macro MEM_MASTER_BUSY_ERR_EN defined: extra output err (1 bit, reset 0) pulses for one cycle the cycle after start=1 is sampled while busy=1; request still ignored.
REQ-035 Macro undefined: no err port; start while busy silently ignored; all else identical.

Verification
REQ-036 Reset: rst low mid-READ with len=7 -> all outputs 0 within same cycle, no done, no rvalid afterwards.
REQ-037 Write then read: write base=2, len=3, data 0x11,0x22,0x33,0x44 with wvalid continuous -> mem_wr at ad 2..5; read back base=2 len=3 -> rvalid x4 with 0x11,0x22,0x33,0x44, done one cycle after last rvalid.
REQ-038 Write stall: len=1, wvalid low 3 cycles between beats -> exactly 2 mem_wr cycles, mem_wr low during stall, done one cycle after second mem_wr.
REQ-039 Wrap: read base=14, len=3 -> mem_ad sequence 14,15,0,1 on consecutive mem_rd cycles; 4 rvalid pulses.
REQ-040 Ignored start: start pulsed during READ and during DONE -> no new burst, busy drops after DONE; with MEM_MASTER_BUSY_ERR_EN err pulses once per such start.
REQ-041 Full burst: write base=0 len=15 values 0x00..0x0F, read back -> 16 rvalid pulses matching, mem_rd high 16 consecutive cycles.
